// File: rtl/sga_move_engine.sv
// sga_move_engine: snake movement, direction latch, move-tick timer and collision flags
// Ports:
//   clock, restart_n      - rising-edge clock, asynchronous active-low reset
//   init, step            - load the initial snake / advance one cell (one-cycle pulses)
//   enable                - move-tick timer runs while high
//   buttons[3:0]          - one-hot direction request: [0] up, [1] down, [2] left, [3] right
//   size[3:0]             - current snake length (0 treated as 1)
//   apple_pos[5:0]        - apple cell index
//   head_pos[5:0]         - seg[0]
//   is_at_apple/border/body - flags for the next move
//   end_play_time         - one-cycle move-tick pulse
//   body_map              - occupancy bitmap, bit i = cell i
//   db_direction[1:0]     - committed direction: 0 up, 1 down, 2 left, 3 right
// Optional feature: define WRAP_EN to wrap the head around the grid edges.
module sga_move_engine #(
    parameter int GRID_W      = 6,
    parameter int GRID_H      = 6,
    parameter int MAX_LEN     = 16,
    parameter int START_POS   = 14,
    parameter int TICK_CYCLES = 1000
) (
    input  logic                     clock,
    input  logic                     restart_n,
    input  logic                     init,
    input  logic                     enable,
    input  logic                     step,
    input  logic [3:0]               buttons,
    input  logic [3:0]               size,
    input  logic [5:0]               apple_pos,
    output logic [5:0]               head_pos,
    output logic                     is_at_apple,
    output logic                     is_at_border,
    output logic                     is_at_body,
    output logic                     end_play_time,
    output logic [GRID_W*GRID_H-1:0] body_map,
    output logic [1:0]               db_direction
);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int CW = $clog2(TICK_CYCLES > 1 ? TICK_CYCLES : 2);
    localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;

    logic [5:0]    seg [MAX_LEN];
    logic [1:0]    dir, pend, req;
    logic [CW-1:0] cnt;
    logic [5:0]    head, row, col, lin_head, next_head;
    logic          e_up, e_dn, e_lt, e_rt, onehot, hit;
    int            len;

    assign head         = seg[0];
    assign head_pos     = seg[0];
    assign db_direction = dir;
    assign row          = head / 6'(GRID_W);
    assign col          = head % 6'(GRID_W);

    // Edge conditions for the pending move
    assign e_up = pend == UP    && row == 6'd0;
    assign e_dn = pend == DOWN  && row == 6'(GRID_H - 1);
    assign e_lt = pend == LEFT  && col == 6'd0;
    assign e_rt = pend == RIGHT && col == 6'(GRID_W - 1);

    assign lin_head = pend == UP   ? head - 6'(GRID_W) :
                      pend == DOWN ? head + 6'(GRID_W) :
                      pend == LEFT ? head - 6'd1 : head + 6'd1;

`ifdef WRAP_EN
    assign is_at_border = 1'b0;
    assign next_head = e_up ? head + 6'((GRID_H - 1) * GRID_W) :
                       e_dn ? head - 6'((GRID_H - 1) * GRID_W) :
                       e_lt ? head + 6'(GRID_W - 1) :
                       e_rt ? head - 6'(GRID_W - 1) : lin_head;
`else
    assign is_at_border = e_up | e_dn | e_lt | e_rt;
    assign next_head    = lin_head;
`endif

    assign len = (size == 4'd0) ? 1 : (int'(size) > MAX_LEN ? MAX_LEN : int'(size));

    // Tail seg[len-1] is excluded from the body check because it vacates its cell
    always_comb begin
        hit      = 1'b0;
        body_map = '0;
        for (int k = 1; k < MAX_LEN; k++)
            if (k <= len - 2 && seg[k] == next_head) hit = 1'b1;
        for (int i = 0; i < CELLS; i++)
            for (int k = 0; k < MAX_LEN; k++)
                if (k < len && seg[k] == 6'(i)) body_map[i] = 1'b1;
    end

    assign is_at_body  = hit && !is_at_border;
    assign is_at_apple = next_head == apple_pos && !is_at_border;

    assign onehot = buttons != 4'd0 && (buttons & (buttons - 4'd1)) == 4'd0;
    assign req    = buttons[0] ? UP : buttons[1] ? DOWN : buttons[2] ? LEFT : RIGHT;

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            for (int k = 0; k < MAX_LEN; k++) seg[k] <= (k == 0) ? 6'(START_POS) : 6'(START_POS - 1);
            dir           <= RIGHT;
            pend          <= RIGHT;
            cnt           <= '0;
            end_play_time <= 1'b0;
        end else begin
            if (init) begin
                for (int k = 0; k < MAX_LEN; k++) seg[k] <= (k == 0) ? 6'(START_POS) : 6'(START_POS - 1);
                dir  <= RIGHT;
                pend <= RIGHT;
            end else begin
                if (step && !is_at_border) begin
                    for (int k = 1; k < MAX_LEN; k++) seg[k] <= seg[k-1];
                    seg[0] <= next_head;
                    dir    <= pend;
                end
                // Reversal is judged against the committed direction, not the pending one
                if (onehot && req != (dir ^ 2'd1)) pend <= req;
            end
            if (init) begin
                cnt           <= '0;
                end_play_time <= 1'b0;
            end else if (enable) begin
                end_play_time <= cnt == CW'(TICK_CYCLES - 1);
                cnt           <= (cnt == CW'(TICK_CYCLES - 1)) ? '0 : cnt + 1'b1;
            end else begin
                end_play_time <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sga_move_engine.sv
// tb_sga_move_engine: self-checking bench for sga_move_engine (TICK_CYCLES = 4)
module tb_sga_move_engine;
  logic clock = 0, restart_n = 0, init = 0, enable = 0, step = 0;
  logic [3:0] buttons = 0, size = 4'd3;
  logic [5:0] apple_pos = 0, head_pos;
  logic is_at_apple, is_at_border, is_at_body, end_play_time;
  logic [35:0] body_map;
  logic [1:0] db_direction;
  sga_move_engine #(.TICK_CYCLES(4)) dut (
    .clock(clock), .restart_n(restart_n), .init(init), .enable(enable), .step(step),
    .buttons(buttons), .size(size), .apple_pos(apple_pos), .head_pos(head_pos),
    .is_at_apple(is_at_apple), .is_at_border(is_at_border), .is_at_body(is_at_body),
    .end_play_time(end_play_time), .body_map(body_map), .db_direction(db_direction)
  );
  always #5 clock = ~clock;
`ifdef WRAP_EN
  localparam longint BORDER = 0, HEAD_EDGE = 12;
`else
  localparam longint BORDER = 1, HEAD_EDGE = 17;
`endif
  localparam int HEAD = 0, APPLE = 1, BRD = 2, BODY = 3, EPT = 4, MAP = 5, DIR = 6;
  int checks = 0, failures = 0;
  function automatic longint b(int i);
    return longint'(1) << i;
  endfunction
  function automatic longint get(int s);
    case (s)
      HEAD:  return longint'(head_pos);
      APPLE: return longint'(is_at_apple);
      BRD:   return longint'(is_at_border);
      BODY:  return longint'(is_at_body);
      EPT:   return longint'(end_play_time);
      MAP:   return longint'(body_map);
      default: return longint'(db_direction);
    endcase
  endfunction
  task automatic ex(string n, int s, longint v);
    longint act;
    act = get(s);
    checks++;
    if (act !== v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, v);
    end
  endtask
  task automatic tick();
    @(posedge clock); #1;
  endtask
  task automatic do_step();
    step = 1; tick(); step = 0;
  endtask
  task automatic press(logic [3:0] bt);
    buttons = bt; tick(); buttons = 0;
  endtask
  task automatic do_reset();
    restart_n = 0; tick(); tick(); restart_n = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    do_reset();
    checks++;
    if (head_pos !== 6'd14) begin failures++; $display("FAIL inl_rst_head: got %0d", head_pos); end
    ex("rst_head", HEAD, 14); ex("rst_dir", DIR, 3); ex("rst_ept", EPT, 0);
    ex("rst_map", MAP, b(13) | b(14)); ex("rst_border", BRD, 0); ex("rst_body", BODY, 0);
    apple_pos = 15; #1;
    ex("apple_now", APPLE, 1);
    do_step(); ex("step1_head", HEAD, 15); ex("step1_apple", APPLE, 0);
    do_step(); ex("step2_head", HEAD, 16);
    do_step(); ex("step3_head", HEAD, 17); ex("step3_map", MAP, b(15) | b(16) | b(17));
    checks++;
    if (body_map !== 36'(b(15) | b(16) | b(17))) begin failures++; $display("FAIL inl_step3_map: got %0h", body_map); end
    ex("step3_dir", DIR, 3); ex("edge_border", BRD, BORDER);
    checks++;
    if (is_at_border !== 1'(BORDER)) begin failures++; $display("FAIL inl_edge_border: got %0b", is_at_border); end
    apple_pos = 18; #1; ex("edge_apple", APPLE, 0);
    do_step(); ex("edge_step_head", HEAD, HEAD_EDGE);
    do_reset();
    press(4'b0100); apple_pos = 15; #1; ex("rev_ignored", APPLE, 1);
    press(4'b0011); ex("multi_ignored", APPLE, 1);
    press(4'b0001); apple_pos = 8; #1; ex("up_pending", APPLE, 1); ex("up_not_commit", DIR, 3);
    do_step(); ex("up_head", HEAD, 8); ex("up_dir", DIR, 0);
    checks++;
    if (db_direction !== 2'd0) begin failures++; $display("FAIL inl_up_dir: got %0d", db_direction); end
    press(4'b0010); apple_pos = 2; #1; ex("down_rev_ignored", APPLE, 1);
    step = 1; buttons = 4'b1000; tick(); step = 0; buttons = 0;
    ex("same_cyc_head", HEAD, 2); ex("same_cyc_dir", DIR, 0);
    do_step(); ex("later_head", HEAD, 3); ex("later_dir", DIR, 3);
    press(4'b0001); ex("top_border", BRD, BORDER);
    do_reset();
    size = 5;
    do_step(); press(4'b0010); do_step(); press(4'b0100); do_step(); press(4'b0001);
    ex("loop_head", HEAD, 20); ex("loop_body5", BODY, 1);
    ex("loop_map5", MAP, b(20) | b(21) | b(15) | b(14) | b(13));
    size = 4; #1; ex("loop_body4", BODY, 0);
    size = 0; #1; ex("size0_map", MAP, b(20));
    size = 4;
    init = 1; step = 1; tick(); init = 0; step = 0;
    ex("init_head", HEAD, 14); ex("init_map", MAP, b(13) | b(14));
    checks++;
    if (head_pos !== 6'd14) begin failures++; $display("FAIL inl_init_head: got %0d", head_pos); end
    do_reset();
    enable = 1;
    for (int k = 1; k <= 12; k++) begin
      tick(); ex($sformatf("tick_a%0d", k), EPT, (k % 4 == 0) ? 1 : 0);
    end
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      enable = (k >= 7 && k <= 9) ? 0 : 1;
      tick(); ex($sformatf("tick_b%0d", k), EPT, (k == 4 || k == 11) ? 1 : 0);
    end
    enable = 1;
    do_reset();
    do_step(); tick();
    restart_n = 0; #1;
    ex("mid_rst_head", HEAD, 14); ex("mid_rst_ept", EPT, 0);
    tick(); restart_n = 1;
    for (int k = 1; k <= 4; k++) begin
      tick(); ex($sformatf("tick_c%0d", k), EPT, (k == 4) ? 1 : 0);
    end
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
